// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle for seg7_scan_ctrl: value/mask inputs, load strobe,
// brightness, and the registered segment/select outputs.
interface seg7_scan_ctrl_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] data;
   logic [DIGITS-1:0]   dp_mask;
   logic [DIGITS-1:0]   blank_mask;
   logic                load;
   logic [3:0]          brightness;
   logic [7:0]          seg_data;
   logic [DIGITS-1:0]   seg_cs;

   modport master (
      output data, dp_mask, blank_mask, load, brightness,
      input  seg_data, seg_cs
   );

   modport slave (
      input  data, dp_mask, blank_mask, load, brightness,
      output seg_data, seg_cs
   );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous double buffering
// and 16-level PWM. Define LZ_BLANK_EN to enable leading-zero suppression.
module seg7_scan_ctrl #(
   parameter int DIGITS    = 4,
   parameter int PHASE_DIV = 6250
) (
   input  logic               clk,
   input  logic               rst_n,
   seg7_scan_ctrl_if.slave    bus
);
   localparam int PRE_W = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PHASE_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [3:0]          phase_q, phase_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [3:0]          bright_q, bright_d;

   logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
   logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
   logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
   logic                pending_q, pending_d;

   logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
   logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
   logic [DIGITS-1:0]   disp_blank_q, disp_blank_d;

   logic [7:0]          seg_data_q, seg_data_d;
   logic [DIGITS-1:0]   seg_cs_q, seg_cs_d;

   logic                pre_wrap, phase_wrap, frame_end, slot_start;
   logic [3:0]          disp_nib [DIGITS];
   logic [DIGITS-1:0]   lz_blank;
   logic [6:0]          glyph;

   function automatic logic [6:0] font7(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         default: g = 7'h71;
      endcase
      return g;
   endfunction

   // Scan timebase: prescaler -> PWM phase -> digit index.
   always_comb begin
      pre_wrap   = (pre_q == PRE_LAST);
      phase_wrap = pre_wrap && (phase_q == 4'd15);
      frame_end  = phase_wrap && (idx_q == IDX_LAST);
      slot_start = (pre_q == '0) && (phase_q == 4'd0);
      pre_d      = pre_wrap ? '0 : pre_q + 1'b1;
      phase_d    = pre_wrap ? phase_q + 4'd1 : phase_q;
      idx_d      = idx_q;
      if (phase_wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      bright_d = slot_start ? bus.brightness : bright_q;
   end

   // Double buffer: a load coinciding with the frame boundary bypasses the shadow.
   always_comb begin
      sh_data_d    = sh_data_q;
      sh_dp_d      = sh_dp_q;
      sh_blank_d   = sh_blank_q;
      pending_d    = pending_q;
      disp_data_d  = disp_data_q;
      disp_dp_d    = disp_dp_q;
      disp_blank_d = disp_blank_q;
      if (bus.load) begin
         sh_data_d  = bus.data;
         sh_dp_d    = bus.dp_mask;
         sh_blank_d = bus.blank_mask;
         pending_d  = 1'b1;
      end
      if (frame_end) begin
         if (bus.load) begin
            disp_data_d  = bus.data;
            disp_dp_d    = bus.dp_mask;
            disp_blank_d = bus.blank_mask;
            pending_d    = 1'b0;
         end else if (pending_q) begin
            disp_data_d  = sh_data_q;
            disp_dp_d    = sh_dp_q;
            disp_blank_d = sh_blank_q;
            pending_d    = 1'b0;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign disp_nib[gi] = disp_data_q[4*gi +: 4];
`ifdef LZ_BLANK_EN
         if (gi == 0) begin : g_lsd
            assign lz_blank[gi] = 1'b0;
         end else begin : g_upper
            // Zero glyphs and no dp from this digit up to the MSD.
            assign lz_blank[gi] = (disp_data_q[4*DIGITS-1:4*gi] == '0) &&
                                  (disp_dp_q[DIGITS-1:gi] == '0);
         end
`else
         assign lz_blank[gi] = 1'b0;
`endif
      end
   endgenerate

   always_comb begin
      glyph      = font7(disp_nib[idx_q]);
      seg_data_d = {disp_dp_q[idx_q], glyph};
      if (disp_blank_q[idx_q] || lz_blank[idx_q]) begin
         seg_data_d = 8'h00;
      end
      // First cycle of every slot is kept dark to hide the segment change.
      seg_cs_d = '0;
      if (!slot_start && (phase_q <= bright_q)) begin
         seg_cs_d[idx_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q        <= '0;
         phase_q      <= '0;
         idx_q        <= '0;
         bright_q     <= '0;
         sh_data_q    <= '0;
         sh_dp_q      <= '0;
         sh_blank_q   <= '0;
         pending_q    <= 1'b0;
         disp_data_q  <= '0;
         disp_dp_q    <= '0;
         disp_blank_q <= '0;
         seg_data_q   <= 8'h00;
         seg_cs_q     <= '0;
      end else begin
         pre_q        <= pre_d;
         phase_q      <= phase_d;
         idx_q        <= idx_d;
         bright_q     <= bright_d;
         sh_data_q    <= sh_data_d;
         sh_dp_q      <= sh_dp_d;
         sh_blank_q   <= sh_blank_d;
         pending_q    <= pending_d;
         disp_data_q  <= disp_data_d;
         disp_dp_q    <= disp_dp_d;
         disp_blank_q <= disp_blank_d;
         seg_data_q   <= seg_data_d;
         seg_cs_q     <= seg_cs_d;
      end
   end

   assign bus.seg_data = seg_data_q;
   assign bus.seg_cs   = seg_cs_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (DIGITS=4, PHASE_DIV=2): a slot/frame
// reference model queues the expected pins per cycle, a monitor compares them.
module tb_seg7_scan_ctrl;
   localparam int D     = 4;
   localparam int PD    = 2;
   localparam int SLOT  = 16 * PD;
   localparam int FRAME = D * SLOT;

   typedef struct {
      logic [7:0]   sd;
      logic [D-1:0] cs;
      int           t;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg7_scan_ctrl_if #(.DIGITS(D)) bus();

   seg7_scan_ctrl #(.DIGITS(D), .PHASE_DIV(PD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int checks = 0;
   int errors = 0;
   bit checking = 1'b0;
   exp_t exp_q[$];

   // Reference state: edges since reset, shadow and displayed frame, slot brightness.
   int             t;
   logic [4*D-1:0] m_sh_data, m_disp_data;
   logic [D-1:0]   m_sh_dp, m_disp_dp, m_sh_blank, m_disp_blank;
   bit             m_pend;
   int             m_bright;

   function automatic exp_t expect_out(int p);
      exp_t e;
      int   off = p % SLOT;
      int   idx = p / SLOT;
      int   nib = int'(m_disp_data[idx*4 +: 4]);
      bit   dark = m_disp_blank[idx];
`ifdef LZ_BLANK_EN
      if (idx > 0 && (m_disp_data >> (4*idx)) == 0 && (m_disp_dp >> idx) == 0) dark = 1'b1;
`endif
      e.sd = dark ? 8'h00 : {m_disp_dp[idx], font_tab[nib]};
      e.cs = (off != 0 && (off / PD) <= m_bright) ? D'(1 << idx) : '0;
      e.t  = t;
      return e;
   endfunction

   task automatic model_reset();
      t = 0;
      m_sh_data = '0; m_disp_data = '0;
      m_sh_dp = '0; m_disp_dp = '0; m_sh_blank = '0; m_disp_blank = '0;
      m_pend = 1'b0;
      m_bright = 0;
   endtask

   task automatic tick();
      int p;
      @(posedge clk);
      p = t % FRAME;
      exp_q.push_back(expect_out(p));
      if (p % SLOT == 0) m_bright = int'(bus.brightness);
      if (p == FRAME - 1 && bus.load) begin
         m_disp_data = bus.data; m_disp_dp = bus.dp_mask; m_disp_blank = bus.blank_mask;
         m_sh_data = bus.data; m_sh_dp = bus.dp_mask; m_sh_blank = bus.blank_mask;
         m_pend = 1'b0;
      end else if (p == FRAME - 1 && m_pend) begin
         m_disp_data = m_sh_data; m_disp_dp = m_sh_dp; m_disp_blank = m_sh_blank;
         m_pend = 1'b0;
      end else if (bus.load) begin
         m_sh_data = bus.data; m_sh_dp = bus.dp_mask; m_sh_blank = bus.blank_mask;
         m_pend = 1'b1;
      end
      t++;
      @(negedge clk);
   endtask

   task automatic run(int n);
      repeat (n) tick();
   endtask

   task automatic do_load(logic [4*D-1:0] dat, logic [D-1:0] dp, logic [D-1:0] bl);
      bus.data = dat; bus.dp_mask = dp; bus.blank_mask = bl;
      bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
   endtask

   task automatic run_to_boundary();
      while (t % FRAME != FRAME - 1) tick();
   endtask

   task automatic check_dark(string name);
      checks++;
      if (bus.seg_data !== 8'h00 || bus.seg_cs !== '0) begin
         errors++;
         $display("FAIL %s: seg_cs=%b seg_data=%h, required seg_cs=0000 seg_data=00",
                  name, bus.seg_cs, bus.seg_data);
      end
   endtask

   // Async reset applied between edges; outputs must clear without a clock.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1 check_dark("reset_async");
      checking = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      check_dark("reset_hold");
      model_reset();
      rst_n = 1'b1;
      checking = 1'b1;
   endtask

   always @(negedge clk) begin
      if (checking && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (bus.seg_cs !== e.cs || bus.seg_data !== e.sd) begin
            errors++;
            $display("FAIL seg t=%0d: seg_cs=%b seg_data=%h, required seg_cs=%b seg_data=%h",
                     e.t, bus.seg_cs, bus.seg_data, e.cs, e.sd);
         end
      end
   end

   initial begin
      bus.data = '0; bus.dp_mask = '0; bus.blank_mask = '0;
      bus.load = 1'b0; bus.brightness = 4'd15;
      model_reset();
      #12 check_dark("reset_init");
      @(negedge clk);
      check_dark("reset_init2");
      rst_n = 1'b1;
      checking = 1'b1;

      // Digits 1234 at full brightness.
      run(5);
      do_load(16'h1234, 4'b0000, 4'b0000);
      run(2 * FRAME);

      // Two loads inside one frame: only the last is ever displayed.
      run(40);
      do_load(16'hABCD, 4'b0000, 4'b0000);
      run(30);
      do_load(16'h5678, 4'b0000, 4'b0000);
      run(2 * FRAME);

      // Brightness extremes and a mid-slot change.
      bus.brightness = 4'd0;
      run(FRAME);
      bus.brightness = 4'd7;
      run(FRAME + 10);
      bus.brightness = 4'd3;
      run(FRAME);
      bus.brightness = 4'd15;

      // Decimal point and per-digit blanking.
      do_load(16'h9876, 4'b0100, 4'b0010);
      run(2 * FRAME);

      // Load landing exactly on the frame-boundary cycle.
      run_to_boundary();
      do_load(16'hC0DE, 4'b0001, 4'b0000);
      run(2 * FRAME);

      // Leading-zero patterns.
      do_load(16'h0050, 4'b0000, 4'b0000);
      run(2 * FRAME);
      do_load(16'h0000, 4'b0000, 4'b0000);
      run(2 * FRAME);
      do_load(16'h0005, 4'b0100, 4'b0000);
      run(2 * FRAME);

      // Randomised traffic.
      for (int i = 0; i < 25; i++) begin
         bus.brightness = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) run_to_boundary();
         do_load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) < 4 ? $urandom : 0));
         run($urandom_range(1, 200));
      end

      // Mid-slot asynchronous reset while a digit is lit.
      bus.brightness = 4'd15;
      do_load(16'h8888, 4'b1111, 4'b0000);
      run(FRAME + 12);
      async_reset();
      run(FRAME / 2);

      @(posedge clk);
      #1;
      checking = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
